// File: rtl/winograd_pad_bridge_if.sv
// Pad/core bus bundle for winograd_pad_bridge.
// The master modport is the bridge side; slave is the pads plus core around it.
interface winograd_pad_bridge_if #(
    parameter int unsigned PAD_W      = 10,
    parameter int unsigned CORE_IN_W  = 40,
    parameter int unsigned CORE_OUT_W = 30
);
    // Input pads
    logic [PAD_W-1:0]      D;
    logic                  D_VLD;
    logic                  D_SOF;
    // Output pads
    logic [PAD_W-1:0]      Z;
    logic                  Z_VLD;
    logic                  Z_SOF;
    // Core input stream
    logic [CORE_IN_W-1:0]  in_data;
    logic                  in_valid;
    logic                  in_ready;
    // Core output stream
    logic [CORE_OUT_W-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    // Sticky status
    logic                  ovf;
    logic                  misalign;

    modport master (
        input  D, D_VLD, D_SOF, in_ready, out_data, out_valid,
        output Z, Z_VLD, Z_SOF, in_data, in_valid, out_ready, ovf, misalign
    );

    modport slave (
        output D, D_VLD, D_SOF, in_ready, out_data, out_valid,
        input  Z, Z_VLD, Z_SOF, in_data, in_valid, out_ready, ovf, misalign
    );
endinterface

// File: rtl/winograd_pad_bridge.sv
// Pad-side bridge: reassembles D-pad beats into core input words through a small
// FIFO, and serialises core results onto the Z pads with a start-of-frame marker.
// Optional feature macro: PAD_BRIDGE_LOOPBACK_EN adds the lpbk port, which routes
// the FIFO head straight into the serialiser instead of the core.
module winograd_pad_bridge #(
    parameter int unsigned PAD_W      = 10,
    parameter int unsigned CORE_IN_W  = 40,
    parameter int unsigned CORE_OUT_W = 30,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef PAD_BRIDGE_LOOPBACK_EN
    input  logic                  lpbk,
`endif
    winograd_pad_bridge_if.master bus
);
    localparam int unsigned BEATS_IN  = CORE_IN_W / PAD_W;
    localparam int unsigned BEATS_OUT = CORE_OUT_W / PAD_W;
    localparam int unsigned BCW       = $clog2(BEATS_IN);
    localparam int unsigned RW        = $clog2(BEATS_OUT);
    localparam int unsigned AW        = $clog2(FIFO_DEPTH);

    typedef enum logic [0:0] {StIdle, StShift} ser_state_e;

    // ---------------- Deserialiser ----------------
    logic [BCW-1:0]       bcnt_q, bcnt_d, beat_idx;
    logic [CORE_IN_W-1:0] asm_q, asm_d;
    logic                 misalign_q, misalign_d;
    logic                 push_req;

    // Place the incoming beat into the word; SOF always restarts at beat 0.
    always_comb begin
        beat_idx   = bus.D_SOF ? '0 : bcnt_q;
        asm_d      = asm_q;
        asm_d[beat_idx*PAD_W +: PAD_W] = bus.D;
        push_req   = bus.D_VLD && (beat_idx == BCW'(BEATS_IN - 1));
        bcnt_d     = bcnt_q;
        misalign_d = misalign_q;
        if (bus.D_VLD) begin
            bcnt_d = push_req ? '0 : beat_idx + 1'b1;
            if (bus.D_SOF && (bcnt_q != '0)) begin
                misalign_d = 1'b1;
            end
        end
    end

    // Beat counter, assembly register and sticky misalign flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_q     <= '0;
            asm_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            bcnt_q     <= bcnt_d;
            misalign_q <= misalign_d;
            if (bus.D_VLD) begin
                asm_q <= asm_d;
            end
        end
    end

    // ---------------- Input FIFO ----------------
    logic [CORE_IN_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]          wptr_q, rptr_q;
    logic [CORE_IN_W-1:0] head;
    logic                 fifo_empty, fifo_full;
    logic                 pop, push_ok, ovf_q;

    assign head       = mem_q[rptr_q[AW-1:0]];
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok    = push_req && (!fifo_full || pop);

    // FIFO storage, pointers and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q[AW-1:0]] <= asm_d;
                wptr_q                <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (push_req && !push_ok) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // ---------------- Serialiser ----------------
    ser_state_e            state_q, state_d;
    logic [RW-1:0]         rem_q, rem_d;
    logic [CORE_OUT_W-1:0] sh_q, sh_d;
    logic [PAD_W-1:0]      z_q, z_d;
    logic                  z_vld_q, z_vld_d, z_sof_q, z_sof_d;
    logic                  ser_ready, capture, src_valid, lb_on;
    logic [CORE_OUT_W-1:0] src_data;

    // rem counts beats still in the shift register; rem == 0 in StShift means the
    // last beat is on Z now, so a new word can be captured without a gap.
    assign ser_ready = (state_q == StIdle) || (rem_q == '0);
    assign capture   = src_valid && ser_ready;

    // Serialiser source: the core, or the FIFO head when looped back.
    always_comb begin
`ifdef PAD_BRIDGE_LOOPBACK_EN
        lb_on = lpbk;
        if (lpbk) begin
            src_valid = !fifo_empty;
            src_data  = CORE_OUT_W'(head);
            pop       = capture;
        end else begin
            src_valid = bus.out_valid;
            src_data  = bus.out_data;
            pop       = !fifo_empty && bus.in_ready;
        end
`else
        lb_on     = 1'b0;
        src_valid = bus.out_valid;
        src_data  = bus.out_data;
        pop       = !fifo_empty && bus.in_ready;
`endif
    end

    // Next-state and next-beat selection for the serialiser FSM.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        z_d     = z_q;
        z_vld_d = 1'b0;
        z_sof_d = 1'b0;
        if (capture) begin
            z_d     = src_data[PAD_W-1:0];
            z_vld_d = 1'b1;
            z_sof_d = 1'b1;
            sh_d    = src_data >> PAD_W;
            rem_d   = RW'(BEATS_OUT - 1);
            state_d = StShift;
        end else if (state_q == StShift) begin
            if (rem_q == '0) begin
                state_d = StIdle;
            end else begin
                z_d     = sh_q[PAD_W-1:0];
                z_vld_d = 1'b1;
                sh_d    = sh_q >> PAD_W;
                rem_d   = rem_q - 1'b1;
            end
        end
    end

    // Serialiser state and registered Z pad outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            sh_q    <= '0;
            z_q     <= '0;
            z_vld_q <= 1'b0;
            z_sof_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
            z_q     <= z_d;
            z_vld_q <= z_vld_d;
            z_sof_q <= z_sof_d;
        end
    end

    assign bus.Z         = z_q;
    assign bus.Z_VLD     = z_vld_q;
    assign bus.Z_SOF     = z_sof_q;
    assign bus.in_data   = head;
    assign bus.in_valid  = !lb_on && !fifo_empty;
    assign bus.out_ready = !lb_on && ser_ready;
    assign bus.ovf       = ovf_q;
    assign bus.misalign  = misalign_q;
endmodule

// File: tb/tb_winograd_pad_bridge.sv
// Directed self-checking bench for winograd_pad_bridge.
module tb_winograd_pad_bridge;
    localparam int unsigned PAD_W      = 10;
    localparam int unsigned CORE_IN_W  = 40;
    localparam int unsigned CORE_OUT_W = 30;
    localparam int unsigned FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
`ifdef PAD_BRIDGE_LOOPBACK_EN
    logic lpbk = 1'b0;
`endif
    int checks = 0;
    int errors = 0;

    // Output words and their hand-split 10-bit beats (LSB beat first).
    localparam logic [29:0] WORD_A = 30'h2345_6789; // beats 389, 159, 234
    localparam logic [29:0] WORD_B = {10'h2AB, 10'h1CD, 10'h0EF}; // beats 0EF, 1CD, 2AB

    winograd_pad_bridge_if #(
        .PAD_W     (PAD_W),
        .CORE_IN_W (CORE_IN_W),
        .CORE_OUT_W(CORE_OUT_W)
    ) bus ();

    winograd_pad_bridge #(
        .PAD_W     (PAD_W),
        .CORE_IN_W (CORE_IN_W),
        .CORE_OUT_W(CORE_OUT_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
`ifdef PAD_BRIDGE_LOOPBACK_EN
        .lpbk(lpbk),
`endif
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [9:0] d, input logic sof);
        bus.D     = d;
        bus.D_VLD = 1'b1;
        bus.D_SOF = sof;
        tick();
        bus.D     = '0;
        bus.D_VLD = 1'b0;
        bus.D_SOF = 1'b0;
    endtask

    task automatic test_reset;
        bus.D = '0; bus.D_VLD = 1'b0; bus.D_SOF = 1'b0;
        bus.in_ready = 1'b0; bus.out_data = '0; bus.out_valid = 1'b0;
        #1 rst = 1'b1;
        #10;
        checks++; if (bus.Z !== 10'h000) begin errors++; $display("FAIL reset_z got %0h want 0", bus.Z); end
        checks++; if (bus.Z_VLD !== 1'b0) begin errors++; $display("FAIL reset_z_vld got %0b want 0", bus.Z_VLD); end
        checks++; if (bus.Z_SOF !== 1'b0) begin errors++; $display("FAIL reset_z_sof got %0b want 0", bus.Z_SOF); end
        checks++; if (bus.in_valid !== 1'b0) begin errors++; $display("FAIL reset_in_valid got %0b want 0", bus.in_valid); end
        checks++; if (bus.in_data !== 40'h0) begin errors++; $display("FAIL reset_in_data got %0h want 0", bus.in_data); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", bus.ovf); end
        checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %0b want 0", bus.misalign); end
        checks++; if (bus.out_ready !== 1'b1) begin errors++; $display("FAIL reset_out_ready got %0b want 1", bus.out_ready); end
        @(negedge clk) rst = 1'b0;
        tick();
    endtask

    task automatic test_single_word;
        logic [39:0] exp_w;
        exp_w = {10'h004, 10'h003, 10'h002, 10'h001};
        bus.in_ready = 1'b1;
        send_beat(10'h001, 1'b1);
        send_beat(10'h002, 1'b0);
        send_beat(10'h003, 1'b0);
        checks++; if (bus.in_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0b want 0", bus.in_valid); end
        send_beat(10'h004, 1'b0);
        checks++; if (bus.in_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", bus.in_valid); end
        checks++; if (bus.in_data !== exp_w) begin errors++; $display("FAIL single_data got %0h want %0h", bus.in_data, exp_w); end
        tick();
        checks++; if (bus.in_valid !== 1'b0) begin errors++; $display("FAIL single_popped got %0b want 0", bus.in_valid); end
        bus.in_ready = 1'b0;
    endtask

    task automatic test_overflow;
        logic [39:0] exp_w;
        for (int w = 0; w < 5; w++) begin
            for (int b = 0; b < 4; b++) begin
                send_beat(10'(w * 16 + b + 1), (b == 0));
            end
            if (w == 3) begin
                checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_at_full got %0b want 0", bus.ovf); end
            end
        end
        checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b want 1", bus.ovf); end
        bus.in_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            exp_w = {10'(w * 16 + 4), 10'(w * 16 + 3), 10'(w * 16 + 2), 10'(w * 16 + 1)};
            checks++; if (bus.in_valid !== 1'b1) begin errors++; $display("FAIL ovf_pop_valid[%0d] got %0b want 1", w, bus.in_valid); end
            checks++; if (bus.in_data !== exp_w) begin errors++; $display("FAIL ovf_pop_data[%0d] got %0h want %0h", w, bus.in_data, exp_w); end
            tick();
        end
        checks++; if (bus.in_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %0b want 0", bus.in_valid); end
        bus.in_ready = 1'b0;
    endtask

    task automatic test_misalign;
        logic [39:0] exp_w;
        exp_w = {10'h055, 10'h044, 10'h033, 10'h3FF};
        send_beat(10'h011, 1'b1);
        send_beat(10'h022, 1'b0);
        checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL misalign_early got %0b want 0", bus.misalign); end
        send_beat(10'h3FF, 1'b1);
        checks++; if (bus.misalign !== 1'b1) begin errors++; $display("FAIL misalign_set got %0b want 1", bus.misalign); end
        send_beat(10'h033, 1'b0);
        send_beat(10'h044, 1'b0);
        send_beat(10'h055, 1'b0);
        checks++; if (bus.in_data !== exp_w) begin errors++; $display("FAIL misalign_data got %0h want %0h", bus.in_data, exp_w); end
        checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", bus.ovf); end
        bus.in_ready = 1'b1;
        tick();
        bus.in_ready = 1'b0;
        checks++; if (bus.in_valid !== 1'b0) begin errors++; $display("FAIL misalign_one_word got %0b want 0", bus.in_valid); end
    endtask

    task automatic test_back_to_back;
        logic [9:0] exp_z [6];
        logic       exp_sof [6];
        exp_z   = '{10'h389, 10'h159, 10'h234, 10'h0EF, 10'h1CD, 10'h2AB};
        exp_sof = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        checks++; if (bus.Z_VLD !== 1'b0) begin errors++; $display("FAIL b2b_idle_vld got %0b want 0", bus.Z_VLD); end
        bus.out_data  = WORD_A;
        bus.out_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin
                checks++; if (bus.out_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy_ready got %0b want 0", bus.out_ready); end
            end
            if (i == 3) begin
                checks++; if (bus.out_ready !== 1'b1) begin errors++; $display("FAIL b2b_last_ready got %0b want 1", bus.out_ready); end
            end
            tick();
            if (i == 0) bus.out_data = WORD_B;
            if (i == 3) bus.out_valid = 1'b0;
            checks++; if (bus.Z_VLD !== 1'b1) begin errors++; $display("FAIL b2b_vld[%0d] got %0b want 1", i, bus.Z_VLD); end
            checks++; if (bus.Z !== exp_z[i]) begin errors++; $display("FAIL b2b_z[%0d] got %0h want %0h", i, bus.Z, exp_z[i]); end
            checks++; if (bus.Z_SOF !== exp_sof[i]) begin errors++; $display("FAIL b2b_sof[%0d] got %0b want %0b", i, bus.Z_SOF, exp_sof[i]); end
        end
        tick();
        checks++; if (bus.Z_VLD !== 1'b0) begin errors++; $display("FAIL b2b_end_vld got %0b want 0", bus.Z_VLD); end
        checks++; if (bus.out_ready !== 1'b1) begin errors++; $display("FAIL b2b_end_ready got %0b want 1", bus.out_ready); end
    endtask

    task automatic test_reset_mid;
        logic [39:0] exp_w;
        exp_w = {10'h1A4, 10'h1A3, 10'h1A2, 10'h1A1};
        send_beat(10'h101, 1'b1);
        send_beat(10'h102, 1'b0);
        bus.out_data  = WORD_A;
        bus.out_valid = 1'b1;
        tick();
        bus.out_valid = 1'b0;
        tick();
        checks++; if (bus.Z !== 10'h159) begin errors++; $display("FAIL rstmid_beat1 got %0h want 159", bus.Z); end
        rst = 1'b1;
        #2;
        checks++; if (bus.Z_VLD !== 1'b0) begin errors++; $display("FAIL rstmid_vld got %0b want 0", bus.Z_VLD); end
        checks++; if (bus.out_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %0b want 1", bus.out_ready); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL rstmid_ovf got %0b want 0", bus.ovf); end
        checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL rstmid_misalign got %0b want 0", bus.misalign); end
        @(negedge clk) rst = 1'b0;
        tick();
        checks++; if (bus.Z_VLD !== 1'b0) begin errors++; $display("FAIL rstmid_post_vld got %0b want 0", bus.Z_VLD); end
        // Partial word was discarded: a fresh 4 beats without SOF form a whole word.
        send_beat(10'h1A1, 1'b0);
        send_beat(10'h1A2, 1'b0);
        send_beat(10'h1A3, 1'b0);
        send_beat(10'h1A4, 1'b0);
        checks++; if (bus.in_data !== exp_w) begin errors++; $display("FAIL rstmid_in_data got %0h want %0h", bus.in_data, exp_w); end
        checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL rstmid_no_misalign got %0b want 0", bus.misalign); end
        bus.in_ready = 1'b1;
        tick();
        bus.in_ready = 1'b0;
        bus.out_data  = WORD_B;
        bus.out_valid = 1'b1;
        tick();
        bus.out_valid = 1'b0;
        checks++; if (bus.Z !== 10'h0EF || bus.Z_SOF !== 1'b1 || bus.Z_VLD !== 1'b1) begin
            errors++; $display("FAIL rstmid_clean_b0 got z=%0h sof=%0b vld=%0b want 0ef 1 1", bus.Z, bus.Z_SOF, bus.Z_VLD);
        end
        tick();
        checks++; if (bus.Z !== 10'h1CD || bus.Z_SOF !== 1'b0) begin errors++; $display("FAIL rstmid_clean_b1 got %0h sof=%0b want 1cd 0", bus.Z, bus.Z_SOF); end
        tick();
        checks++; if (bus.Z !== 10'h2AB) begin errors++; $display("FAIL rstmid_clean_b2 got %0h want 2ab", bus.Z); end
        tick();
        checks++; if (bus.Z_VLD !== 1'b0) begin errors++; $display("FAIL rstmid_clean_end got %0b want 0", bus.Z_VLD); end
    endtask

`ifdef PAD_BRIDGE_LOOPBACK_EN
    task automatic test_loopback;
        lpbk = 1'b1;
        bus.in_ready = 1'b1;
        send_beat(10'h00A, 1'b1);
        send_beat(10'h00B, 1'b0);
        send_beat(10'h00C, 1'b0);
        send_beat(10'h00D, 1'b0);
        checks++; if (bus.in_valid !== 1'b0) begin errors++; $display("FAIL lpbk_in_valid got %0b want 0", bus.in_valid); end
        checks++; if (bus.out_ready !== 1'b0) begin errors++; $display("FAIL lpbk_out_ready got %0b want 0", bus.out_ready); end
        checks++; if (bus.Z_VLD !== 1'b0) begin errors++; $display("FAIL lpbk_pre_vld got %0b want 0", bus.Z_VLD); end
        tick();
        checks++; if (bus.Z !== 10'h00A || bus.Z_SOF !== 1'b1 || bus.Z_VLD !== 1'b1) begin
            errors++; $display("FAIL lpbk_b0 got z=%0h sof=%0b vld=%0b want 00a 1 1", bus.Z, bus.Z_SOF, bus.Z_VLD);
        end
        tick();
        checks++; if (bus.Z !== 10'h00B || bus.Z_SOF !== 1'b0) begin errors++; $display("FAIL lpbk_b1 got %0h sof=%0b want 00b 0", bus.Z, bus.Z_SOF); end
        tick();
        checks++; if (bus.Z !== 10'h00C) begin errors++; $display("FAIL lpbk_b2 got %0h want 00c", bus.Z); end
        tick();
        checks++; if (bus.Z_VLD !== 1'b0) begin errors++; $display("FAIL lpbk_end got %0b want 0", bus.Z_VLD); end
        lpbk = 1'b0;
        #1;
        checks++; if (bus.in_valid !== 1'b0) begin errors++; $display("FAIL lpbk_fifo_drained got %0b want 0", bus.in_valid); end
        bus.in_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_overflow();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
`ifdef PAD_BRIDGE_LOOPBACK_EN
        test_loopback();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
